// File: rtl/a_res_sched_pkg.sv
// Shared constants, A-bus source codes and slot record for the A-register result scheduler.
package a_res_sched_pkg;

  localparam int unsigned DELAY_W    = 4;
  localparam int unsigned SRC_W      = 4;
  localparam int unsigned AREG_W     = 3;
  localparam int unsigned NUM_AREG   = 8;
  localparam int unsigned SLOT_DEPTH = (1 << DELAY_W) - 1;

  // A-bus source select codes
  localparam logic [SRC_W-1:0] ABUS_NONE = 4'd0;
  localparam logic [SRC_W-1:0] ABUS_IMM  = 4'd1;
  localparam logic [SRC_W-1:0] ABUS_MEM  = 4'd2;
  localparam logic [SRC_W-1:0] ABUS_ADD  = 4'd3;
  localparam logic [SRC_W-1:0] ABUS_MUL  = 4'd4;
  localparam logic [SRC_W-1:0] ABUS_POP  = 4'd5;
  localparam logic [SRC_W-1:0] ABUS_SREG = 4'd6;

  typedef struct packed {
    logic              valid;
    logic [SRC_W-1:0]  src;
    logic [AREG_W-1:0] dest;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A zero delay on a register-writing instruction still needs one cycle to reach the write port.
  function automatic logic [DELAY_W-1:0] eff_delay(input logic [DELAY_W-1:0] delay,
                                                   input logic              dest_en);
    logic [DELAY_W-1:0] res;
    res = delay;
    if (dest_en && (delay == '0)) begin
      res = DELAY_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/a_res_sched_if.sv
// Issue-side and write-back signals of the A-register result scheduler.
interface a_res_sched_if;
  import a_res_sched_pkg::*;

  logic                i_issue;
  logic                i_dest_en;
  logic [DELAY_W-1:0]  i_delay;
  logic [SRC_W-1:0]    i_src;
  logic [AREG_W-1:0]   i_dest;
  logic                o_issue_ok;
  logic                o_wb_valid;
  logic [SRC_W-1:0]    o_wb_src;
  logic [AREG_W-1:0]   o_wb_dest;
  logic [NUM_AREG-1:0] o_a_busy;

  modport master (
    output i_issue, i_dest_en, i_delay, i_src, i_dest,
    input  o_issue_ok, o_wb_valid, o_wb_src, o_wb_dest, o_a_busy
  );

  modport slave (
    input  i_issue, i_dest_en, i_delay, i_src, i_dest,
    output o_issue_ok, o_wb_valid, o_wb_src, o_wb_dest, o_a_busy
  );

endinterface

// File: rtl/a_res_wheel.sv
// Timing wheel: slot k holds the write-back due k cycles from now; shifts one slot per clock,
// with an indexed insert (by delay) and an indexed occupancy lookup.
module a_res_wheel
  import a_res_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ins_en,
  input  logic [DELAY_W-1:0] ins_delay,
  input  slot_t              ins_slot,
  input  logic [DELAY_W-1:0] look_delay,
  output logic               look_valid,
  output slot_t              head
);

  localparam logic [DELAY_W-1:0] MaxDelay = DELAY_W'(SLOT_DEPTH);

  slot_t              slot_q [SLOT_DEPTH];
  slot_t              slot_d [SLOT_DEPTH];
  logic [DELAY_W-1:0] ins_idx;

  assign ins_idx = ins_delay - DELAY_W'(1);

  // An insert lands one slot below its delay because the whole wheel advances on the same edge.
  always_comb begin
    for (int k = 0; k < SLOT_DEPTH - 1; k++) begin
      slot_d[k] = slot_q[k+1];
    end
    slot_d[SLOT_DEPTH-1] = SLOT_EMPTY;
    if (ins_en && (ins_delay != '0)) begin
      slot_d[ins_idx] = ins_slot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < SLOT_DEPTH; k++) begin
        slot_q[k] <= SLOT_EMPTY;
      end
    end else begin
      for (int k = 0; k < SLOT_DEPTH; k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  always_comb begin
    look_valid = 1'b0;
    if (look_delay != MaxDelay) begin
      look_valid = slot_q[look_delay].valid;
    end
  end

  // Empty slots are stored as all-zero, so head fields are already 0 when not valid.
  assign head = slot_q[0];

endmodule

// File: rtl/a_res_sched.sv
// A-register result scheduler: times A-register write-backs and tracks per-register reservations.
// A_RES_SLOT_CHECK_EN makes issue also stall on a write-back slot collision.
module a_res_sched
  import a_res_sched_pkg::*;
(
  input logic          clk,
  input logic          rst,
  a_res_sched_if.slave bus
);

  logic [NUM_AREG-1:0] busy_q;
  logic [NUM_AREG-1:0] busy_d;
  logic [DELAY_W-1:0]  deff;
  logic                look_valid;
  logic                coll;
  logic                issue_ok;
  logic                acc;
  slot_t               ins_slot;
  slot_t               head;

  assign deff = eff_delay(bus.i_delay, bus.i_dest_en);

`ifdef A_RES_SLOT_CHECK_EN
  assign coll = look_valid;
`else
  logic unused_look_valid;
  assign unused_look_valid = look_valid;
  assign coll = 1'b0;
`endif

  always_comb begin
    issue_ok = 1'b1;
    if (bus.i_dest_en) begin
      issue_ok = !busy_q[bus.i_dest] && !coll;
    end
  end

  assign acc = bus.i_issue && bus.i_dest_en && issue_ok;

  always_comb begin
    ins_slot       = SLOT_EMPTY;
    ins_slot.valid = 1'b1;
    ins_slot.src   = bus.i_src;
    ins_slot.dest  = bus.i_dest;
  end

  a_res_wheel u_wheel (
    .clk        (clk),
    .rst        (rst),
    .ins_en     (acc),
    .ins_delay  (deff),
    .ins_slot   (ins_slot),
    .look_delay (deff),
    .look_valid (look_valid),
    .head       (head)
  );

  // Set after clear so a same-cycle reissue to the retiring register keeps its reservation.
  always_comb begin
    busy_d = busy_q;
    if (head.valid) begin
      busy_d[head.dest] = 1'b0;
    end
    if (acc) begin
      busy_d[bus.i_dest] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.o_issue_ok = issue_ok;
  assign bus.o_wb_valid = head.valid;
  assign bus.o_wb_src   = head.src;
  assign bus.o_wb_dest  = head.dest;
  assign bus.o_a_busy   = busy_q;

endmodule

// File: tb/tb_a_res_sched.sv
// Scoreboard bench for a_res_sched: directed issues push expected write-backs, a monitor checks them.
module tb_a_res_sched;
  import a_res_sched_pkg::*;

  typedef struct {
    int                due;
    logic [SRC_W-1:0]  src;
    logic [AREG_W-1:0] dest;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  a_res_sched_if sif ();

  a_res_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    sif.i_issue   = 1'b0;
    sif.i_dest_en = 1'b0;
    sif.i_delay   = '0;
    sif.i_src     = '0;
    sif.i_dest    = '0;
  endtask

  // Present one issue request for one cycle; on expected acceptance record the write-back.
  task automatic try_issue(input string name, input logic den, input int delay,
                           input logic [SRC_W-1:0] src, input logic [AREG_W-1:0] dest,
                           input logic exp_ok);
    sif.i_issue   = 1'b1;
    sif.i_dest_en = den;
    sif.i_delay   = DELAY_W'(delay);
    sif.i_src     = src;
    sif.i_dest    = dest;
    #1;
    chk({name, "_ok"}, {31'd0, sif.o_issue_ok}, {31'd0, exp_ok});
    if (den && exp_ok) begin
      sb.push_back('{cyc + ((delay == 0) ? 1 : delay), src, dest});
    end
    step();
    idle();
  endtask

  always @(negedge clk) begin
    int idx;
    if (rst) begin
      idx = -1;
      for (int i = 0; i < sb.size(); i++) begin
        if (sb[i].due == cyc) idx = i;
      end
      if (sif.o_wb_valid) begin
        if (idx < 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL wb_unexpected: cycle %0d got dest %0d src %0d, required no write-back",
                   cyc, sif.o_wb_dest, sif.o_wb_src);
        end else begin
          chk("wb_dest", {29'd0, sif.o_wb_dest}, {29'd0, sb[idx].dest});
          chk("wb_src", {28'd0, sif.o_wb_src}, {28'd0, sb[idx].src});
          sb.delete(idx);
        end
      end else if (idx >= 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wb_missing: cycle %0d got no write-back, required dest %0d src %0d",
                 cyc, sb[idx].dest, sb[idx].src);
        sb.delete(idx);
      end else begin
        chk("wb_idle_zero", {25'd0, sif.o_wb_src, sif.o_wb_dest}, 32'd0);
      end
    end
  end

  initial begin
    idle();
    #1 rst = 1'b0;
    #1;
    chk("rst_wb_valid", {31'd0, sif.o_wb_valid}, 32'd0);
    chk("rst_wb_src", {28'd0, sif.o_wb_src}, 32'd0);
    chk("rst_wb_dest", {29'd0, sif.o_wb_dest}, 32'd0);
    chk("rst_busy", {24'd0, sif.o_a_busy}, 32'd0);
    chk("rst_issue_ok_noden", {31'd0, sif.o_issue_ok}, 32'd1);
    sif.i_dest_en = 1'b1;
    sif.i_dest    = 3'd3;
    sif.i_delay   = 4'd2;
    #1;
    chk("rst_issue_ok_den", {31'd0, sif.o_issue_ok}, 32'd1);
    idle();
    #9 rst = 1'b1;
    step();

    // Single delay-1 write-back and its reservation window
    try_issue("t1", 1'b1, 1, ABUS_IMM, 3'd3, 1'b1);
    chk("t1_busy_set", {31'd0, sif.o_a_busy[3]}, 32'd1);
    step();
    chk("t1_busy_clr", {31'd0, sif.o_a_busy[3]}, 32'd0);
    step();

    // Out-of-order completion
    try_issue("t2a", 1'b1, 6, ABUS_MEM, 3'd2, 1'b1);
    try_issue("t2b", 1'b1, 2, ABUS_ADD, 3'd5, 1'b1);
    chk("t2_busy", {24'd0, sif.o_a_busy}, 32'h24);
    step(6);

    // Write-back slot collision
    try_issue("t3a", 1'b1, 4, ABUS_ADD, 3'd1, 1'b1);
`ifdef A_RES_SLOT_CHECK_EN
    try_issue("t3_coll", 1'b1, 3, ABUS_MUL, 3'd4, 1'b0);
`else
    step();
`endif
    try_issue("t3b", 1'b1, 3, ABUS_MUL, 3'd4, 1'b1);
    step(5);

    // Same-register reissue blocked through the write-back cycle
    try_issue("t4a", 1'b1, 5, ABUS_MEM, 3'd7, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      try_issue("t4_blocked", 1'b1, 1, ABUS_IMM, 3'd7, 1'b0);
    end
    try_issue("t4_after", 1'b1, 1, ABUS_IMM, 3'd7, 1'b1);
    step(2);

    // Delay 0 is clamped to 1
    try_issue("t5", 1'b1, 0, ABUS_MUL, 3'd6, 1'b1);
    chk("t5_busy_set", {31'd0, sif.o_a_busy[6]}, 32'd1);
    step();
    chk("t5_busy_clr", {31'd0, sif.o_a_busy[6]}, 32'd0);

    // Issue without an A destination
    try_issue("t6", 1'b0, 3, ABUS_MEM, 3'd0, 1'b1);
    chk("t6_busy", {24'd0, sif.o_a_busy}, 32'd0);
    step(4);

    // Reset with write-backs in flight
    try_issue("t7a", 1'b1, 5, ABUS_IMM, 3'd0, 1'b1);
    try_issue("t7b", 1'b1, 9, ABUS_MEM, 3'd1, 1'b1);
    try_issue("t7c", 1'b1, 10, ABUS_ADD, 3'd2, 1'b1);
    chk("t7_busy", {24'd0, sif.o_a_busy}, 32'h07);
    step(2);
    chk("t7_wb_pre", {31'd0, sif.o_wb_valid}, 32'd1);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("t7_rst_wb_valid", {31'd0, sif.o_wb_valid}, 32'd0);
    chk("t7_rst_wb_dest", {29'd0, sif.o_wb_dest}, 32'd0);
    chk("t7_rst_busy", {24'd0, sif.o_a_busy}, 32'd0);
    step(2);
    rst = 1'b1;
    step(14);
    chk("t7_post_busy", {24'd0, sif.o_a_busy}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
